// File: rtl/instr_prefetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : instr_prefetch_pkg
//  Description : Shared opcode constants and instruction-length decode for
//                the instruction prefetch unit.
//                  OP_HLT      - halt opcode (stops fetch when the optional
//                                PREFETCH_HLT_STOP_EN build macro is defined)
//                  OP_LIMM     - two-word opcode (load immediate)
//                  OP_D0       - two-word opcode
//                  is_two_word - 1 when an opcode carries an operand word
//  Revision    : 1.0 - initial release
// ============================================================================
package instr_prefetch_pkg;

    localparam logic [7:0] OP_HLT  = 8'hFF;
    localparam logic [7:0] OP_LIMM = 8'h01;
    localparam logic [7:0] OP_D0   = 8'hD0;

    function automatic logic is_two_word(input logic [7:0] op);
        return (op == OP_LIMM) || (op == OP_D0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_prefetch_pf_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : pf_fifo
//  Description : Register-array FIFO of {word, address} pairs. One write per
//                cycle, pop of one or two entries, synchronous flush, and
//                combinational read of the head entry and the entry behind it.
//  Ports       : clk, reset          - clock, synchronous active-high reset
//                i_flush             - empty the FIFO (pointers back to 0)
//                i_wr_en/word/addr   - tail write
//                i_pop, i_pop_two    - pop 1 entry, or 2 when i_pop_two=1
//                o_count             - number of valid entries
//                o_head_word/addr    - head entry
//                o_next_word         - word behind the head
//  Revision    : 1.0 - initial release
// ============================================================================
module pf_fifo #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_flush,
    input  logic                    i_wr_en,
    input  logic [31:0]             i_wr_word,
    input  logic [ADDR_W-1:0]       i_wr_addr,
    input  logic                    i_pop,
    input  logic                    i_pop_two,
    output logic [$clog2(DEPTH):0]  o_count,
    output logic [31:0]             o_head_word,
    output logic [ADDR_W-1:0]       o_head_addr,
    output logic [31:0]             o_next_word
);

    localparam int c_PTR_W = $clog2(DEPTH);

    logic [31:0]        r_word [DEPTH];
    logic [ADDR_W-1:0]  r_addr [DEPTH];
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W:0]   r_count;
    logic [c_PTR_W:0]   w_pop_n;
    logic [c_PTR_W-1:0] w_rd_ptr_nxt;

    // DEPTH is a power of two, so pointer arithmetic wraps naturally.
    assign w_rd_ptr_nxt = r_rd_ptr + 1'b1;
    assign w_pop_n      = i_pop ? (i_pop_two ? (c_PTR_W+1)'(2) : (c_PTR_W+1)'(1))
                                : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            // Storage is cleared so the head outputs read zero after reset.
            for (int i = 0; i < DEPTH; i++) begin
                r_word[i] <= '0;
                r_addr[i] <= '0;
            end
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_wr_en) begin
                r_word[r_wr_ptr] <= i_wr_word;
                r_addr[r_wr_ptr] <= i_wr_addr;
                r_wr_ptr         <= r_wr_ptr + 1'b1;
            end
            r_rd_ptr <= r_rd_ptr + w_pop_n[c_PTR_W-1:0];
            r_count  <= r_count + (c_PTR_W+1)'(i_wr_en) - w_pop_n;
        end
    end

    assign o_count     = r_count;
    assign o_head_word = r_word[r_rd_ptr];
    assign o_head_addr = r_addr[r_rd_ptr];
    assign o_next_word = r_word[w_rd_ptr_nxt];

endmodule
`default_nettype wire

// File: rtl/instr_prefetch.sv
`default_nettype none
// ============================================================================
//  Module      : instr_prefetch
//  Description : Instruction prefetch unit. Reads 32-bit words ahead of
//                execution from a 1-cycle-latency program memory into a small
//                FIFO and presents whole one- or two-word instructions on a
//                valid/ready handshake. A redirect flushes and restarts fetch.
//                Optional build macro PREFETCH_HLT_STOP_EN: stop issuing reads
//                once an OP_HLT word at an instruction boundary is written.
//  Ports       : clk, reset                 - clock, sync active-high reset
//                mem_rd_en, mem_addr        - program memory read request
//                mem_rdata                  - read data, 1 cycle after request
//                redirect, redirect_pc      - flush and restart at new PC
//                instr_valid, instr_ready   - instruction handshake
//                instr0, instr1, instr_two  - instruction words / length
//                instr_pc                   - address of instr0
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_prefetch #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr0,
    output logic [31:0]       instr1,
    output logic              instr_two,
    output logic [ADDR_W-1:0] instr_pc
);

    import instr_prefetch_pkg::*;

    localparam int c_CNT_W = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0]  r_fpc;
    logic [ADDR_W-1:0]  r_rd_addr;
    logic               r_inflight;
    logic               r_inflight_epoch;
    logic               r_epoch;
    logic               r_opflag;

    logic [c_CNT_W-1:0] w_count;
    logic [31:0]        w_head_word;
    logic [31:0]        w_next_word;
    logic [ADDR_W-1:0]  w_head_addr;
    logic               w_wr_en;
    logic               w_stop;
    logic               w_issue;
    logic               w_head_two;
    logic               w_pop;

    // A returning word is kept only if it belongs to the current fetch
    // stream; a redirect in the return cycle flushes it as well.
    assign w_wr_en = r_inflight && (r_inflight_epoch == r_epoch) && !redirect;

`ifdef PREFETCH_HLT_STOP_EN
    logic r_stop;
    logic w_hlt_hit;

    // Operand words are never opcodes, so the HLT match is masked while the
    // write side is between an opcode word and its operand. The hit also
    // blocks the read in the same cycle so nothing past HLT is requested.
    assign w_hlt_hit = w_wr_en && !r_opflag && (mem_rdata[31:24] == OP_HLT);
    assign w_stop    = r_stop || w_hlt_hit;

    always_ff @(posedge clk) begin
        if (reset || redirect) begin
            r_stop <= 1'b0;
        end else if (w_hlt_hit) begin
            r_stop <= 1'b1;
        end
    end
`else
    assign w_stop = 1'b0;
`endif

    // Credit uses the registered count only; a pop in this cycle does not
    // free a slot until the next one.
    assign w_issue = ((w_count + c_CNT_W'(r_inflight)) < c_CNT_W'(DEPTH))
                     && !redirect && !w_stop && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fpc            <= '0;
            r_rd_addr        <= '0;
            r_inflight       <= 1'b0;
            r_inflight_epoch <= 1'b0;
            r_epoch          <= 1'b0;
            r_opflag         <= 1'b0;
        end else if (redirect) begin
            r_fpc      <= redirect_pc;
            r_inflight <= 1'b0;
            r_epoch    <= ~r_epoch;
            r_opflag   <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_fpc            <= r_fpc + 1'b1;
                r_rd_addr        <= r_fpc;
                r_inflight_epoch <= r_epoch;
            end
            if (w_wr_en) begin
                r_opflag <= r_opflag ? 1'b0 : is_two_word(mem_rdata[31:24]);
            end
        end
    end

    pf_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_flush     (redirect),
        .i_wr_en     (w_wr_en),
        .i_wr_word   (mem_rdata),
        .i_wr_addr   (r_rd_addr),
        .i_pop       (w_pop),
        .i_pop_two   (w_head_two),
        .o_count     (w_count),
        .o_head_word (w_head_word),
        .o_head_addr (w_head_addr),
        .o_next_word (w_next_word)
    );

    assign w_head_two  = is_two_word(w_head_word[31:24]);
    assign instr_valid = !redirect && (w_count != '0)
                         && (!w_head_two || (w_count >= c_CNT_W'(2)));
    assign w_pop       = instr_valid && instr_ready;

    assign mem_rd_en = w_issue;
    assign mem_addr  = r_fpc;
    assign instr0    = w_head_word;
    assign instr1    = w_head_two ? w_next_word : 32'h0;
    assign instr_two = w_head_two;
    assign instr_pc  = w_head_addr;

endmodule
`default_nettype wire

// File: tb/tb_instr_prefetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_prefetch
//  Description : Directed self-checking bench for instr_prefetch with a
//                1-cycle-latency program memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_prefetch;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_rdata = 32'h0;
    logic              redirect = 1'b0;
    logic [ADDR_W-1:0] redirect_pc = '0;
    logic              instr_valid;
    logic              instr_ready = 1'b0;
    logic [31:0]       instr0;
    logic [31:0]       instr1;
    logic              instr_two;
    logic [ADDR_W-1:0] instr_pc;

    logic [31:0] mem [0:65535];
    int n_pass  = 0;
    int n_total = 0;

    instr_prefetch #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr0      (instr0),
        .instr1      (instr1),
        .instr_two   (instr_two),
        .instr_pc    (instr_pc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    // One-word filler: opcode 0x30..0x4F, low half = address.
    function automatic logic [31:0] dflt(input int a);
        logic [4:0] lo;
        lo = a[4:0];
        return {8'h30 + {3'b000, lo}, 8'h00, a[15:0]};
    endfunction

    // Leaves the bench at a negedge with reset still high, after a reset edge.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; redirect = 1'b0; instr_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_total++; if (mem_rd_en !== 1'b0) $display("FAIL reset_rd_en: got %b want 0", mem_rd_en); else n_pass++;
        n_total++; if (instr_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", instr_valid); else n_pass++;
        n_total++; if (instr0 !== 32'h0) $display("FAIL reset_instr0: got %h want 0", instr0); else n_pass++;
        n_total++; if (instr1 !== 32'h0) $display("FAIL reset_instr1: got %h want 0", instr1); else n_pass++;
        n_total++; if (instr_pc !== 16'h0) $display("FAIL reset_pc: got %h want 0", instr_pc); else n_pass++;
        n_total++; if (instr_two !== 1'b0) $display("FAIL reset_two: got %b want 0", instr_two); else n_pass++;
    endtask

    task automatic test_one_word();
        do_reset();
        mem[0] = 32'h3000_0000;
        mem[1] = 32'h3100_0000;
        reset = 1'b0; instr_ready = 1'b1;
        #1;
        n_total++; if (mem_rd_en !== 1'b1 || mem_addr !== 16'h0) $display("FAIL c0_read: got en=%b addr=%h want en=1 addr=0000", mem_rd_en, mem_addr); else n_pass++;
        n_total++; if (instr_valid !== 1'b0) $display("FAIL c0_valid: got %b want 0", instr_valid); else n_pass++;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk); #1;
            n_total++; if (mem_rd_en !== 1'b1 || mem_addr !== 16'(c)) $display("FAIL stream_read c%0d: got en=%b addr=%h want en=1 addr=%h", c, mem_rd_en, mem_addr, 16'(c)); else n_pass++;
            if (c == 1) begin
                n_total++; if (instr_valid !== 1'b0) $display("FAIL c1_valid: got %b want 0", instr_valid); else n_pass++;
            end else begin
                n_total++; if (instr_valid !== 1'b1 || instr_pc !== 16'(c-2) || instr0 !== mem[c-2] || instr1 !== 32'h0 || instr_two !== 1'b0)
                    $display("FAIL stream_instr c%0d: got v=%b pc=%h i0=%h i1=%h two=%b want v=1 pc=%h i0=%h i1=0 two=0", c, instr_valid, instr_pc, instr0, instr1, instr_two, 16'(c-2), mem[c-2]);
                else n_pass++;
            end
        end
        mem[0] = dflt(0); mem[1] = dflt(1);
    endtask

    task automatic test_two_word();
        do_reset();
        mem[0] = 32'h0100_0005;
        mem[1] = 32'h0000_1234;
        reset = 1'b0; instr_ready = 1'b1;
        #1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        n_total++; if (instr_valid !== 1'b0) $display("FAIL two_c2_valid: got %b want 0", instr_valid); else n_pass++;
        @(negedge clk); #1;
        n_total++; if (instr_valid !== 1'b1 || instr0 !== 32'h0100_0005 || instr1 !== 32'h0000_1234 || instr_two !== 1'b1 || instr_pc !== 16'h0)
            $display("FAIL two_c3: got v=%b i0=%h i1=%h two=%b pc=%h want v=1 i0=01000005 i1=00001234 two=1 pc=0000", instr_valid, instr0, instr1, instr_two, instr_pc);
        else n_pass++;
        @(negedge clk); #1;
        n_total++; if (instr_valid !== 1'b1 || instr_pc !== 16'h2 || instr_two !== 1'b0 || instr0 !== dflt(2))
            $display("FAIL two_next: got v=%b pc=%h two=%b i0=%h want v=1 pc=0002 two=0 i0=%h", instr_valid, instr_pc, instr_two, instr0, dflt(2));
        else n_pass++;
        mem[0] = dflt(0); mem[1] = dflt(1);
    endtask

    task automatic test_back_pressure();
        int reads;
        int e;
        reads = 0;
        do_reset();
        reset = 1'b0; instr_ready = 1'b0;
        #1;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) begin @(negedge clk); #1; end
            if (mem_rd_en === 1'b1) reads++;
        end
        n_total++; if (reads != DEPTH) $display("FAIL bp_reads: got %0d want %0d", reads, DEPTH); else n_pass++;
        n_total++; if (mem_rd_en !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== 16'h0)
            $display("FAIL bp_full: got en=%b v=%b pc=%h want en=0 v=1 pc=0000", mem_rd_en, instr_valid, instr_pc);
        else n_pass++;
        e = 0;
        for (int c = 0; c < 30 && e < 8; c++) begin
            @(negedge clk);
            instr_ready = 1'b1;
            #1;
            if (instr_valid === 1'b1) begin
                n_total++; if (instr_pc !== 16'(e) || instr0 !== dflt(e))
                    $display("FAIL bp_order #%0d: got pc=%h i0=%h want pc=%h i0=%h", e, instr_pc, instr0, 16'(e), dflt(e));
                else n_pass++;
                e++;
            end
        end
        n_total++; if (e != 8) $display("FAIL bp_drain: got %0d instructions want 8", e); else n_pass++;
    endtask

    task automatic test_redirect();
        do_reset();
        reset = 1'b0; instr_ready = 1'b1;
        #1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        @(negedge clk);
        redirect = 1'b1; redirect_pc = 16'h0040;
        #1;
        n_total++; if (instr_valid !== 1'b0 || mem_rd_en !== 1'b0) $display("FAIL redir_cycle: got v=%b en=%b want v=0 en=0", instr_valid, mem_rd_en); else n_pass++;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        n_total++; if (mem_rd_en !== 1'b1 || mem_addr !== 16'h0040) $display("FAIL redir_read: got en=%b addr=%h want en=1 addr=0040", mem_rd_en, mem_addr); else n_pass++;
        n_total++; if (instr_valid !== 1'b0) $display("FAIL redir_stale_r1: got v=%b want 0", instr_valid); else n_pass++;
        @(negedge clk); #1;
        n_total++; if (instr_valid !== 1'b0) $display("FAIL redir_stale_r2: got v=%b want 0", instr_valid); else n_pass++;
        @(negedge clk); #1;
        n_total++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0040 || instr0 !== dflt(16'h40))
            $display("FAIL redir_instr: got v=%b pc=%h i0=%h want v=1 pc=0040 i0=%h", instr_valid, instr_pc, instr0, dflt(16'h40));
        else n_pass++;
    endtask

    task automatic test_wrap_and_reset();
        logic [15:0] exp_pc [3];
        exp_pc[0] = 16'hFFFE; exp_pc[1] = 16'hFFFF; exp_pc[2] = 16'h0000;
        do_reset();
        reset = 1'b0; instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 16'hFFFE;
        #1;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        n_total++; if (mem_addr !== 16'hFFFE || mem_rd_en !== 1'b1) $display("FAIL wrap_rd0: got en=%b addr=%h want en=1 addr=fffe", mem_rd_en, mem_addr); else n_pass++;
        @(negedge clk); #1;
        n_total++; if (mem_addr !== 16'hFFFF || mem_rd_en !== 1'b1) $display("FAIL wrap_rd1: got en=%b addr=%h want en=1 addr=ffff", mem_rd_en, mem_addr); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            if (k == 0) begin
                n_total++; if (mem_addr !== 16'h0000 || mem_rd_en !== 1'b1) $display("FAIL wrap_rd2: got en=%b addr=%h want en=1 addr=0000", mem_rd_en, mem_addr); else n_pass++;
            end
            n_total++; if (instr_valid !== 1'b1 || instr_pc !== exp_pc[k] || instr0 !== dflt(int'(exp_pc[k])))
                $display("FAIL wrap_instr #%0d: got v=%b pc=%h i0=%h want v=1 pc=%h i0=%h", k, instr_valid, instr_pc, instr0, exp_pc[k], dflt(int'(exp_pc[k])));
            else n_pass++;
        end
        // Reset while the stream is running.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk); #1;
        n_total++; if (instr_valid !== 1'b0 || mem_rd_en !== 1'b0) $display("FAIL midrst: got v=%b en=%b want v=0 en=0", instr_valid, mem_rd_en); else n_pass++;
        reset = 1'b0;
        #1;
        n_total++; if (mem_rd_en !== 1'b1 || mem_addr !== 16'h0 || instr_valid !== 1'b0)
            $display("FAIL midrst_c0: got en=%b addr=%h v=%b want en=1 addr=0000 v=0", mem_rd_en, mem_addr, instr_valid);
        else n_pass++;
        @(negedge clk); #1;
        n_total++; if (instr_valid !== 1'b0) $display("FAIL midrst_c1: got v=%b want 0", instr_valid); else n_pass++;
        @(negedge clk); #1;
        n_total++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0) $display("FAIL midrst_c2: got v=%b pc=%h want v=1 pc=0000", instr_valid, instr_pc); else n_pass++;
    endtask

`ifdef PREFETCH_HLT_STOP_EN
    task automatic test_hlt();
        int max_addr;
        int n_acc;
        logic [15:0] acc [3];
        max_addr = 0; n_acc = 0;
        mem[0] = 32'h0100_0000;
        mem[1] = 32'hFF00_0000;
        mem[2] = 32'h3000_0002;
        mem[3] = 32'hFF00_0003;
        do_reset();
        reset = 1'b0; instr_ready = 1'b1;
        #1;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) begin @(negedge clk); #1; end
            if (mem_rd_en === 1'b1 && int'(mem_addr) > max_addr) max_addr = int'(mem_addr);
            if (instr_valid === 1'b1) begin
                if (n_acc < 3) acc[n_acc] = instr_pc;
                n_acc++;
            end
        end
        n_total++; if (max_addr != 3) $display("FAIL hlt_max_addr: got %0d want 3", max_addr); else n_pass++;
        n_total++; if (n_acc != 3) $display("FAIL hlt_count: got %0d want 3", n_acc); else n_pass++;
        n_total++; if (acc[0] !== 16'h0 || acc[1] !== 16'h2 || acc[2] !== 16'h3)
            $display("FAIL hlt_pcs: got %h %h %h want 0000 0002 0003", acc[0], acc[1], acc[2]);
        else n_pass++;
        for (int a = 0; a < 4; a++) mem[a] = dflt(a);
    endtask
`endif

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = dflt(a);
        test_reset();
        test_one_word();
        test_two_word();
        test_back_pressure();
        test_redirect();
        test_wrap_and_reset();
`ifdef PREFETCH_HLT_STOP_EN
        test_hlt();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d", n_pass, n_total);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/instr_prefetch.md
# instr_prefetch

Instruction prefetch unit between the synchronous program memory and the controller. It runs ahead of execution to fetch 32-bit words into a small FIFO and groups them into whole one- or two-word instructions. Each complete instruction is handed to the controller over a valid/ready handshake. A redirect input flushes the unit and restarts fetch at a new PC.

## Interface
- DEPTH, 4, FIFO entries in words; power of two, ≥2
- ADDR_W, 16, program address width
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- mem_rd_en  out  1  program memory read strobe
- mem_addr  out  ADDR_W  read address; valid when mem_rd_en=1
- mem_rdata  in  32  read data; valid exactly one cycle after the mem_rd_en cycle
- redirect  in  1  flush and restart fetch (jump/branch)
- redirect_pc  in  ADDR_W  restart address; sampled when redirect=1
- instr_valid  out  1  complete instruction at FIFO head
- instr_ready  in  1  controller accepts the instruction
- instr0  out  32  first word; opcode in [31:24]
- instr1  out  32  second word; 0 for one-word instructions
- instr_two  out  1  1 = two-word instruction
- instr_pc  out  ADDR_W  address of instr0

## Operation
- State: fetch PC fpc, FIFO of {word, addr}, count, in-flight flag, epoch bit, write-side operand flag.
- Issue: mem_rd_en=1 when count + inflight < DEPTH, redirect=0 and fetch is not stopped. mem_addr=fpc, and fpc increments. fpc wraps from 2^ADDR_W−1 to 0.
- Return: the word from the previous cycle's read is written to the tail with its address, unless its epoch differs from the current epoch. Stale words are discarded.
- Two-word opcodes are 8'h01 and 8'hD0. All other opcodes are one word.
- instr_valid=1 when both hold:
  - count≥1
  - the head is one-word, or the head is two-word with count≥2
- instr_valid is forced to 0 in any cycle with redirect=1.
- When instr_valid=1, instr0, instr1, instr_two and instr_pc are driven combinationally from the head entries. When instr_valid=0, they hold the head contents and have no meaning.
- Transfer happens on instr_valid & instr_ready. The FIFO pops 1 word for a one-word instruction and 2 words for a two-word instruction.
- Redirect: count←0, epoch toggles, fpc←redirect_pc, operand flag←0, fetch restarts. There is no read in the redirect cycle. The first read of redirect_pc is issued the following cycle.
- Operand flag: set after a two-word opcode word is written and cleared after its operand is written. It marks instruction boundaries on the write side.
- Reset: fpc=0, count=0, inflight=0, epoch=0, operand flag=0, stop=0. Outputs read 0: mem_rd_en=0, instr_valid=0, instr0/instr1/instr_pc=0, instr_two=0. Reset also cancels any in-flight return.

## Timing
- Cycle 0 is the first cycle with reset=0: mem_rd_en=1, mem_addr=0.
- Cycle 1: word 0 is on mem_rdata and is written at the end of the cycle.
- Cycle 2: instr_valid=1 for a one-word instruction. A two-word instruction is valid at cycle 3.
- Redirect in cycle R: read of redirect_pc in R+1, instruction valid in R+3 at the earliest.
- The credit check uses registered count only; a same-cycle pop does not free a slot. With DEPTH≥4 the unit still sustains 1 word/cycle.
- Simultaneous redirect and returning read: the return is dropped (epoch mismatch).
- Full FIFO: no issue. Empty FIFO: instr_valid=0.

## Configuration
- PREFETCH_HLT_STOP_EN defined: when a word at an instruction boundary with opcode OP_HLT is written, stop←1 and no further reads are issued until redirect or reset. A word written while the operand flag is set is never treated as HLT.
- PREFETCH_HLT_STOP_EN undefined: no stop logic; fetch continues until the FIFO is full.

## Structure
- Shared package/def header holds: OP_HLT, the two-word opcode constants (OP_LIMM=8'h01, OP_D0=8'hD0), and an is_two_word(op) function.
- One sub-module, pf_fifo: a register-array FIFO with one write per cycle, pop of 1 or 2 words, flush, and combinational head and head+1 read.

## Test plan
- Reset release with memory 0:0x30000000, 1:0x31000000 → mem_addr 0,1,… from cycle 0. Instr @0 valid at cycle 2 with instr_two=0, instr1=0; ready=1 gives one instruction per cycle.
- Two-word: mem 0:0x01000005, 1:0x00001234 → instr0=0x01000005, instr1=0x00001234, instr_two=1, instr_pc=0, valid at cycle 3. Next instr_pc=2.
- Back-pressure: instr_ready=0 for 10 cycles → at most DEPTH words held, mem_rd_en=0 when full. No loss or reorder after release.
- Redirect to 0x0040 while a read is in flight → stale word discarded. Next accepted instruction has instr_pc=0x0040, and instr_valid=0 in the redirect cycle.
- With PREFETCH_HLT_STOP_EN, HLT at address 3 → no reads past address 3. An operand word 0xFF…, equal to OP_HLT, at address 1 following 0x01 does not stop fetch.
- fpc at 0xFFFF → next read at 0x0000. A reset mid-burst gives instr_valid=0 and a next read at 0.
